// File: rtl/mips_ctrl_pkg.sv
// Shared opcode/funct encodings, datapath select codes and controller states
// for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_RWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_JUMP
    } state_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Single shared instruction/data memory port handshake.
// The controller is the master; the memory answers with mem_ack.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ack
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// R-type funct to ALU control decode, with a flag for supported functs.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       funct_valid_o
);

    always_comb begin
        alu_ctrl_o    = ALU_ADD;
        funct_valid_o = 1'b1;
        case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: funct_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS controller: sequences the shared datapath per state
// and counts retired instructions.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    multicycle_ctrl_if.master mem,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             RegDst,
    output logic             ALUsrc,
    output logic             MemtoReg,
    output logic             reg_we,
    output logic             ext_op,
    output logic [2:0]       alu_ctrl,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic             req, we;
    logic [2:0]       fn_alu;
    logic             fn_ok;

    logic is_r, is_lw, is_sw, is_beq, is_addi, is_ori, is_j;

    assign is_r    = (opcode == OP_RTYPE);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_addi = (opcode == OP_ADDI);
    assign is_ori  = (opcode == OP_ORI);
    assign is_j    = (opcode == OP_J);

    alu_decoder u_alu_dec (
        .funct_i      (funct),
        .alu_ctrl_o   (fn_alu),
        .funct_valid_o(fn_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req        = 1'b0;
        we         = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SEQ;
        RegDst     = 1'b0;
        ALUsrc     = 1'b0;
        MemtoReg   = 1'b0;
        reg_we     = 1'b0;
        ext_op     = 1'b0;
        alu_ctrl   = ALU_ADD;
        illegal_op = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                req = 1'b1;
                if (mem.mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_r && fn_ok,
                    is_addi,
                    is_ori:          state_d = S_EXEC;
                    is_lw || is_sw:  state_d = S_MEMADR;
                    is_beq:          state_d = S_BRANCH;
                    is_j:            state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_ctrl = fn_alu;
                end else if (is_addi) begin
                    ALUsrc = 1'b1;
                    ext_op = 1'b1;
                end else begin
                    ALUsrc   = 1'b1;
                    alu_ctrl = ALU_OR;
                end
                state_d = S_RWB;
            end
            S_RWB: begin
                reg_we  = 1'b1;
                RegDst  = is_r;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                ALUsrc  = 1'b1;
                ext_op  = 1'b1;
                state_d = is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                req = 1'b1;
                if (mem.mem_ack) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_we   = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                req = 1'b1;
                we  = 1'b1;
                if (mem.mem_ack) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_ctrl = ALU_SUB;
                pc_we    = zero;
                pc_src   = PC_BR;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_we   = 1'b1;
                pc_src  = PC_JMP;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_RST;
        endcase
    end

    assign mem.mem_req = req;
    assign mem.mem_we  = we;

    // Counter wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt_q <= '0;
        else if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues the expected
// output vector per cycle, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    typedef logic [18:0] vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       ir_we, pc_we, RegDst, ALUsrc, MemtoReg;
    logic       reg_we, ext_op, illegal_op;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] instr_retired;

    multicycle_ctrl_if mif();

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .mem          (mif),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .RegDst       (RegDst),
        .ALUsrc       (ALUsrc),
        .MemtoReg     (MemtoReg),
        .reg_we       (reg_we),
        .ext_op       (ext_op),
        .alu_ctrl     (alu_ctrl),
        .illegal_op   (illegal_op),
        .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    vec_t expq[$];
    int   tagq[$];
    int   checks = 0;
    int   errors = 0;
    int   nstep  = 0;
    logic [3:0] c;

    // Field order: req we ir_we pc_we pc_src RegDst ALUsrc MemtoReg
    // reg_we ext_op alu_ctrl illegal_op instr_retired
    function automatic vec_t ex(
        input logic r, w, ir, pw, input logic [1:0] ps,
        input logic rd, as, mr, rw, eo, input logic [2:0] ac,
        input logic il, input logic [3:0] cn);
        return {r, w, ir, pw, ps, rd, as, mr, rw, eo, ac, il, cn};
    endfunction

    function automatic vec_t e_rst();
        return ex(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 3'b010, 0, 4'd0);
    endfunction
    function automatic vec_t e_fetch(input logic a, input logic [3:0] cn);
        return ex(1, 0, a, a, 2'd0, 0, 0, 0, 0, 0, 3'b010, 0, cn);
    endfunction
    function automatic vec_t e_dec(input logic il, input logic [3:0] cn);
        return ex(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 3'b010, il, cn);
    endfunction
    function automatic vec_t e_exec(input logic as, eo, input logic [2:0] ac,
                                    input logic [3:0] cn);
        return ex(0, 0, 0, 0, 2'd0, 0, as, 0, 0, eo, ac, 0, cn);
    endfunction
    function automatic vec_t e_rwb(input logic rd, input logic [3:0] cn);
        return ex(0, 0, 0, 0, 2'd0, rd, 0, 0, 1, 0, 3'b010, 0, cn);
    endfunction
    function automatic vec_t e_madr(input logic [3:0] cn);
        return ex(0, 0, 0, 0, 2'd0, 0, 1, 0, 0, 1, 3'b010, 0, cn);
    endfunction
    function automatic vec_t e_mrd(input logic [3:0] cn);
        return ex(1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 3'b010, 0, cn);
    endfunction
    function automatic vec_t e_mwb(input logic [3:0] cn);
        return ex(0, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0, 3'b010, 0, cn);
    endfunction
    function automatic vec_t e_mwr(input logic [3:0] cn);
        return ex(1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 3'b010, 0, cn);
    endfunction
    function automatic vec_t e_br(input logic z, input logic [3:0] cn);
        return ex(0, 0, 0, z, 2'd1, 0, 0, 0, 0, 0, 3'b110, 0, cn);
    endfunction
    function automatic vec_t e_jmp(input logic [3:0] cn);
        return ex(0, 0, 0, 1, 2'd2, 0, 0, 0, 0, 0, 3'b010, 0, cn);
    endfunction

    task automatic step(input logic r, a, z, input vec_t e);
        rst_n       = r;
        mif.mem_ack = a;
        zero        = z;
        expq.push_back(e);
        tagq.push_back(nstep);
        nstep++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            vec_t exp_v, act;
            int   tag;
            exp_v = expq.pop_front();
            tag   = tagq.pop_front();
            act = {mif.mem_req, mif.mem_we, ir_we, pc_we, pc_src, RegDst,
                   ALUsrc, MemtoReg, reg_we, ext_op, alu_ctrl, illegal_op,
                   instr_retired};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL step%0d outputs got %b want %b",
                         tag, act, exp_v);
            end
        end
    end

    logic [5:0] fns [5];
    logic [2:0] acs [5];
    int         wt;

    initial begin
        fns = '{6'b100000, 6'b100010, 6'b101010, 6'b100101, 6'b100100};
        acs = '{3'b010, 3'b110, 3'b111, 3'b001, 3'b000};
        rst_n = 1'b0; mif.mem_ack = 1'b0; zero = 1'b0;
        opcode = 6'b0; funct = 6'b0;
        #1;
        checks++;
        if (mif.mem_req !== 1'b0 || mif.mem_we !== 1'b0 ||
            ir_we !== 1'b0 || pc_we !== 1'b0 || reg_we !== 1'b0 ||
            alu_ctrl !== 3'b010 || instr_retired !== 4'd0) begin
            errors++;
            $display("FAIL reset state req=%b cnt=%0d ac=%b",
                     mif.mem_req, instr_retired, alu_ctrl);
        end
        @(posedge clk); #1;
        step(0, 1, 0, e_rst());
        step(1, 1, 0, e_rst());
        c = 4'd0;

        for (int i = 0; i < 5; i++) begin
            opcode = 6'b000000; funct = fns[i];
            step(1, 1, 0, e_fetch(1, c));
            step(1, 1, 0, e_dec(0, c));
            step(1, 1, 0, e_exec(0, 0, acs[i], c));
            step(1, 1, 0, e_rwb(1, c));
            c++;
        end

        opcode = 6'b001000; funct = 6'b100010;
        step(1, 1, 0, e_fetch(1, c));
        step(1, 1, 0, e_dec(0, c));
        step(1, 1, 0, e_exec(1, 1, 3'b010, c));
        step(1, 1, 0, e_rwb(0, c));
        c++;

        opcode = 6'b001101;
        step(1, 1, 0, e_fetch(1, c));
        step(1, 1, 0, e_dec(0, c));
        step(1, 1, 0, e_exec(1, 0, 3'b001, c));
        step(1, 1, 0, e_rwb(0, c));
        c++;

        opcode = 6'b100011;
        step(1, 1, 0, e_fetch(1, c));
        step(1, 1, 0, e_dec(0, c));
        step(1, 1, 0, e_madr(c));
        repeat (3) step(1, 0, 0, e_mrd(c));
        step(1, 1, 0, e_mrd(c));
        step(1, 1, 0, e_mwb(c));
        c++;

        opcode = 6'b101011;
        step(1, 0, 0, e_fetch(0, c));
        step(1, 1, 0, e_fetch(1, c));
        step(1, 1, 0, e_dec(0, c));
        step(1, 1, 0, e_madr(c));
        step(1, 0, 0, e_mwr(c));
        step(1, 1, 0, e_mwr(c));
        c++;

        opcode = 6'b000100;
        step(1, 1, 0, e_fetch(1, c));
        step(1, 1, 0, e_dec(0, c));
        step(1, 1, 1, e_br(1, c));
        c++;
        step(1, 1, 0, e_fetch(1, c));
        step(1, 1, 0, e_dec(0, c));
        step(1, 1, 0, e_br(0, c));
        c++;

        opcode = 6'b000010;
        step(1, 1, 0, e_fetch(1, c));
        step(1, 1, 0, e_dec(0, c));
        step(1, 1, 0, e_jmp(c));
        c++;

        opcode = 6'b111111;
        step(1, 1, 0, e_fetch(1, c));
        step(1, 1, 0, e_dec(1, c));
        opcode = 6'b000000; funct = 6'b000111;
        step(1, 1, 0, e_fetch(1, c));
        step(1, 1, 0, e_dec(1, c));

        opcode = 6'b101011;
        step(1, 1, 0, e_fetch(1, c));
        step(1, 1, 0, e_dec(0, c));
        step(1, 1, 0, e_madr(c));
        step(1, 0, 0, e_mwr(c));
        rst_n = 1'b0;
        #1;
        checks++;
        if (mif.mem_req !== 1'b0 || instr_retired !== 4'd0) begin
            errors++;
            $display("FAIL async reset req=%b cnt=%0d",
                     mif.mem_req, instr_retired);
        end
        step(0, 0, 0, e_rst());
        step(1, 0, 0, e_rst());
        c = 4'd0;

        opcode = 6'b000010;
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0, e_fetch(1, c));
            step(1, 1, 0, e_dec(0, c));
            step(1, 1, 0, e_jmp(c));
            c++;
        end
        step(1, 1, 0, e_fetch(1, c));

        wt = 0;
        while (expq.size() > 0 && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        #1;
        checks++;
        if (expq.size() != 0 || instr_retired !== 4'd0) begin
            errors++;
            $display("FAIL wait expired pending=%0d cnt=%0d",
                     expq.size(), instr_retired);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
